// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code set 2 key tracker: strips F0/E0 prefixes, skips E1 Pause and status bytes, queues make/break events.
// Optional macro PS2_KEY_REPEAT_EN: typematic repeats are queued with evt_repeat=1 instead of being discarded.
module ps2_key_tracker #(
    parameter int EVT_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte_data,
    output logic             o_key_held,
    output logic [7:0]       o_key_code,
    output logic             o_key_ext,
    output logic [CNT_W-1:0] o_press_cnt,
    output logic             o_evt_valid,
    input  logic             i_evt_ready,
    output logic [7:0]       o_evt_code,
    output logic             o_evt_ext,
    output logic             o_evt_break,
    output logic             o_evt_repeat,
    output logic             o_overflow
);

    localparam int AW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
`ifdef PS2_KEY_REPEAT_EN
    localparam int EW = 11;
`else
    localparam int EW = 10;
`endif

    typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, SKIP} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [2:0]       r_skipCnt;
    logic             r_keyHeld;
    logic [7:0]       r_keyCode;
    logic             r_keyExt;
    logic [CNT_W-1:0] r_pressCnt;
    logic             r_overflow;
    logic [EW-1:0]    r_fifo [EVT_DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;

    logic             w_doMake;
    logic             w_doBreak;
    logic             w_ext;
    logic             w_isStatus;
    logic             w_isPrefix;
    logic             w_keyMatch;
    logic             w_isRepeat;
    logic             w_newPress;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic [EW-1:0]    w_pushData;
    logic [EW-1:0]    w_head;

    assign w_isStatus = (i_byte_data == 8'h00) || (i_byte_data == 8'hAA) ||
                        (i_byte_data == 8'hEE) || (i_byte_data == 8'hFA) ||
                        (i_byte_data == 8'hFE) || (i_byte_data == 8'hFF);
    assign w_isPrefix = (i_byte_data == 8'hF0) || (i_byte_data == 8'hE0) ||
                        (i_byte_data == 8'hE1);

    always_comb begin
        w_nextState = r_state;
        w_doMake    = 1'b0;
        w_doBreak   = 1'b0;
        w_ext       = 1'b0;
        if (i_byte_valid) begin
            case (r_state)
                IDLE: begin
                    if (i_byte_data == 8'hF0)      w_nextState = BRK;
                    else if (i_byte_data == 8'hE0) w_nextState = EXT;
                    else if (i_byte_data == 8'hE1) w_nextState = SKIP;
                    else if (!w_isStatus)          w_doMake = 1'b1;
                end
                EXT: begin
                    if (i_byte_data == 8'hF0) begin
                        w_nextState = EXT_BRK;
                    end else begin
                        w_nextState = IDLE;
                        w_doMake    = !(w_isPrefix || w_isStatus);
                        w_ext       = 1'b1;
                    end
                end
                BRK, EXT_BRK: begin
                    w_nextState = IDLE;
                    w_doBreak   = !(w_isPrefix || w_isStatus);
                    w_ext       = (r_state == EXT_BRK);
                end
                SKIP: begin
                    if (r_skipCnt == 3'd1) w_nextState = IDLE;
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // A make for the key already held is typematic, not a new press
    assign w_keyMatch = ({r_keyExt, r_keyCode} == {w_ext, i_byte_data});
    assign w_isRepeat = w_doMake && r_keyHeld && w_keyMatch;
    assign w_newPress = w_doMake && !w_isRepeat;

`ifdef PS2_KEY_REPEAT_EN
    assign w_push     = w_newPress || w_doBreak || w_isRepeat;
    assign w_pushData = {w_isRepeat, w_doBreak, w_ext, i_byte_data};
`else
    assign w_push     = w_newPress || w_doBreak;
    assign w_pushData = {w_doBreak, w_ext, i_byte_data};
`endif

    assign w_empty = (r_wrPtr == r_rdPtr);
    assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                     (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign w_pop   = !w_empty && i_evt_ready;
    assign w_head  = r_fifo[r_rdPtr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_skipCnt  <= 3'd0;
            r_keyHeld  <= 1'b0;
            r_keyCode  <= 8'h00;
            r_keyExt   <= 1'b0;
            r_pressCnt <= '0;
            r_overflow <= 1'b0;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            for (int i = 0; i < EVT_DEPTH; i++) r_fifo[i] <= '0;
        end else begin
            r_state <= w_nextState;
            if (i_byte_valid) begin
                if (r_state == IDLE && i_byte_data == 8'hE1) r_skipCnt <= 3'd7;
                else if (r_state == SKIP)                     r_skipCnt <= r_skipCnt - 3'd1;
            end
            if (w_newPress) begin
                r_keyHeld  <= 1'b1;
                r_keyCode  <= i_byte_data;
                r_keyExt   <= w_ext;
                r_pressCnt <= r_pressCnt + CNT_W'(1);
            end else if (w_doBreak && w_keyMatch) begin
                r_keyHeld <= 1'b0;
            end
            if (w_pop) r_rdPtr <= r_rdPtr + (AW+1)'(1);
            // A same-cycle pop frees the slot, so a push into a full FIFO still lands
            if (w_push && (!w_full || w_pop)) begin
                r_fifo[r_wrPtr[AW-1:0]] <= w_pushData;
                r_wrPtr                 <= r_wrPtr + (AW+1)'(1);
            end else if (w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_key_held  = r_keyHeld;
    assign o_key_code  = r_keyCode;
    assign o_key_ext   = r_keyExt;
    assign o_press_cnt = r_pressCnt;
    assign o_overflow  = r_overflow;
    assign o_evt_valid = !w_empty;
    assign o_evt_code  = w_head[7:0];
    assign o_evt_ext   = w_head[8];
    assign o_evt_break = w_head[9];
`ifdef PS2_KEY_REPEAT_EN
    assign o_evt_repeat = w_head[10];
`else
    assign o_evt_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: byte vector table plus overflow, full-FIFO pop/push and mid-sequence reset sequences.
module tb_ps2_key_tracker;

    localparam int CNT_W     = 16;
    localparam int EVT_DEPTH = 4;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_byte_valid;
    logic [7:0]       i_byte_data;
    logic             o_key_held;
    logic [7:0]       o_key_code;
    logic             o_key_ext;
    logic [CNT_W-1:0] o_press_cnt;
    logic             o_evt_valid;
    logic             i_evt_ready;
    logic [7:0]       o_evt_code;
    logic             o_evt_ext;
    logic             o_evt_break;
    logic             o_evt_repeat;
    logic             o_overflow;

    ps2_key_tracker #(.EVT_DEPTH(EVT_DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data),
        .o_key_held(o_key_held), .o_key_code(o_key_code), .o_key_ext(o_key_ext),
        .o_press_cnt(o_press_cnt), .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
        .o_evt_code(o_evt_code), .o_evt_ext(o_evt_ext), .o_evt_break(o_evt_break),
        .o_evt_repeat(o_evt_repeat), .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    // evt: 0 none, 1 make, 2 break, 3 typematic repeat
    typedef struct {
        logic [7:0]  b;
        logic [1:0]  evt;
        logic        ext;
        logic        held;
        logic [7:0]  code;
        logic        kext;
        logic [15:0] cnt;
    } vec_t;
    typedef logic [10:0] ev_t;

    ev_t  sbQ[$];
    vec_t vecs[48];
    int   nVec = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  gotEv;
    ev_t  expEv;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [7:0] b, input logic [1:0] evt, input logic ext,
                          input logic held, input logic [7:0] code, input logic kext,
                          input logic [15:0] cnt);
        vecs[nVec] = '{b, evt, ext, held, code, kext, cnt};
        nVec++;
    endtask

    task automatic pushExp(input logic [1:0] evt, input logic ext, input logic [7:0] b);
        if (evt == 2'd1) sbQ.push_back({1'b0, 1'b0, ext, b});
        else if (evt == 2'd2) sbQ.push_back({1'b0, 1'b1, ext, b});
`ifdef PS2_KEY_REPEAT_EN
        else if (evt == 2'd3) sbQ.push_back({1'b1, 1'b0, ext, b});
`endif
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic rdy);
        @(posedge i_clk);
        #1;
        i_evt_ready  = rdy;
        i_byte_valid = 1'b1;
        i_byte_data  = b;
        @(posedge i_clk);
        #1;
        i_byte_valid = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic checkHeld(input string tag, input logic held, input logic [7:0] code,
                             input logic kext, input logic [15:0] cnt);
        checkOutput({tag, "_held"}, 16'(o_key_held), 16'(held));
        checkOutput({tag, "_code"}, 16'(o_key_code), 16'(code));
        checkOutput({tag, "_ext"},  16'(o_key_ext),  16'(kext));
        checkOutput({tag, "_cnt"},  o_press_cnt,     cnt);
    endtask

    task automatic checkResetState(input string tag);
        checkHeld(tag, 1'b0, 8'h00, 1'b0, 16'd0);
        checkOutput({tag, "_evt_valid"}, 16'(o_evt_valid), 16'd0);
        checkOutput({tag, "_evt_fields"}, 16'({o_evt_repeat, o_evt_break, o_evt_ext, o_evt_code}), 16'd0);
        checkOutput({tag, "_overflow"}, 16'(o_overflow), 16'd0);
    endtask

    task automatic waitDrain(input string tag);
        @(posedge i_clk);
        #1;
        i_evt_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge i_clk);
            if (sbQ.size() == 0 && !o_evt_valid) break;
        end
        checkOutput({tag, "_drain_left"}, 16'(sbQ.size()), 16'd0);
        checkOutput({tag, "_drain_valid"}, 16'(o_evt_valid), 16'd0);
    endtask

    // Scoreboard: every accepted head event must match the oldest expected one
    always @(negedge i_clk) begin
        if (!i_rst && o_evt_valid && i_evt_ready) begin
            gotEv = {o_evt_repeat, o_evt_break, o_evt_ext, o_evt_code};
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL evt_unexpected: got %h, required none", gotEv);
            end else begin
                expEv = sbQ.pop_front();
                if (gotEv !== expEv) begin
                    errors++;
                    $display("[TB] FAIL evt_head: got %h, required %h", gotEv, expEv);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        i_rst        = 1'b1;
        i_byte_valid = 1'b0;
        i_byte_data  = 8'h00;
        i_evt_ready  = 1'b1;

        // Basic make/break, extended keys, distinct non-extended key
        addVec(8'h1C, 2'd1, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd1);
        addVec(8'hF0, 2'd0, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd1);
        addVec(8'h1C, 2'd2, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd1);
        addVec(8'hE0, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd1);
        addVec(8'h75, 2'd1, 1'b1, 1'b1, 8'h75, 1'b1, 16'd2);
        addVec(8'hE0, 2'd0, 1'b0, 1'b1, 8'h75, 1'b1, 16'd2);
        addVec(8'hF0, 2'd0, 1'b0, 1'b1, 8'h75, 1'b1, 16'd2);
        addVec(8'h75, 2'd2, 1'b1, 1'b0, 8'h75, 1'b1, 16'd2);
        addVec(8'h75, 2'd1, 1'b0, 1'b1, 8'h75, 1'b0, 16'd3);
        addVec(8'hF0, 2'd0, 1'b0, 1'b1, 8'h75, 1'b0, 16'd3);
        addVec(8'h75, 2'd2, 1'b0, 1'b0, 8'h75, 1'b0, 16'd3);
        // Typematic repeats
        addVec(8'h1C, 2'd1, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd4);
        addVec(8'h1C, 2'd3, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd4);
        addVec(8'h1C, 2'd3, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd4);
        addVec(8'hF0, 2'd0, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd4);
        addVec(8'h1C, 2'd2, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd4);
        // Pause sequence, then status bytes in IDLE
        addVec(8'hE1, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd4);
        addVec(8'h14, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd4);
        addVec(8'h77, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd4);
        addVec(8'hE1, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd4);
        addVec(8'hF0, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd4);
        addVec(8'h14, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd4);
        addVec(8'hF0, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd4);
        addVec(8'h77, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd4);
        addVec(8'h16, 2'd1, 1'b0, 1'b1, 8'h16, 1'b0, 16'd5);
        addVec(8'hAA, 2'd0, 1'b0, 1'b1, 8'h16, 1'b0, 16'd5);
        addVec(8'hFA, 2'd0, 1'b0, 1'b1, 8'h16, 1'b0, 16'd5);
        addVec(8'hF0, 2'd0, 1'b0, 1'b1, 8'h16, 1'b0, 16'd5);
        addVec(8'h16, 2'd2, 1'b0, 1'b0, 8'h16, 1'b0, 16'd5);
        // Non-matching break keeps the held key; break followed by status is discarded
        addVec(8'h1C, 2'd1, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd6);
        addVec(8'hF0, 2'd0, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd6);
        addVec(8'h29, 2'd2, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd6);
        addVec(8'hF0, 2'd0, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd6);
        addVec(8'h1C, 2'd2, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd6);
        addVec(8'hF0, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd6);
        addVec(8'hAA, 2'd0, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd6);
        addVec(8'h1C, 2'd1, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd7);
        addVec(8'hF0, 2'd0, 1'b0, 1'b1, 8'h1C, 1'b0, 16'd7);
        addVec(8'h1C, 2'd2, 1'b0, 1'b0, 8'h1C, 1'b0, 16'd7);

        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checkResetState("reset");

        for (int i = 0; i < nVec; i++) begin
            pushExp(vecs[i].evt, vecs[i].ext, vecs[i].b);
            applyStimulus(vecs[i].b, 1'b1);
            checkHeld($sformatf("vec%0d", i), vecs[i].held, vecs[i].code, vecs[i].kext, vecs[i].cnt);
        end
        waitDrain("table");

        // Overflow: EVT_DEPTH+1 distinct makes with the consumer stalled
        begin
            logic [7:0] keys [5];
            keys = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
            for (int i = 0; i < 5; i++) begin
                if (i < EVT_DEPTH) pushExp(2'd1, 1'b0, keys[i]);
                applyStimulus(keys[i], 1'b0);
            end
        end
        checkOutput("ovf_flag", 16'(o_overflow), 16'd1);
        checkOutput("ovf_valid", 16'(o_evt_valid), 16'd1);
        checkHeld("ovf", 1'b1, 8'h2C, 1'b0, 16'd12);
        waitDrain("ovf");
        checkOutput("ovf_sticky", 16'(o_overflow), 16'd1);

        // Reset right after F0, with a byte offered during reset that must be ignored
        applyStimulus(8'hF0, 1'b1);
        @(posedge i_clk);
        #1;
        i_rst        = 1'b1;
        i_byte_valid = 1'b1;
        i_byte_data  = 8'h1C;
        @(posedge i_clk);
        #1;
        i_rst        = 1'b0;
        i_byte_valid = 1'b0;
        @(negedge i_clk);
        checkResetState("midrst");
        pushExp(2'd1, 1'b0, 8'h1C);
        applyStimulus(8'h1C, 1'b1);
        checkHeld("midrst_make", 1'b1, 8'h1C, 1'b0, 16'd1);
        pushExp(2'd2, 1'b0, 8'h1C);
        applyStimulus(8'hF0, 1'b1);
        applyStimulus(8'h1C, 1'b1);
        checkHeld("midrst_brk", 1'b0, 8'h1C, 1'b0, 16'd1);
        waitDrain("midrst");

        // Full FIFO with a simultaneous pop and push must not overflow
        begin
            logic [7:0] keys [4];
            keys = '{8'h15, 8'h1D, 8'h24, 8'h2D};
            for (int i = 0; i < 4; i++) begin
                pushExp(2'd1, 1'b0, keys[i]);
                applyStimulus(keys[i], 1'b0);
            end
        end
        checkOutput("full_valid", 16'(o_evt_valid), 16'd1);
        checkOutput("full_noovf", 16'(o_overflow), 16'd0);
        pushExp(2'd1, 1'b0, 8'h2C);
        applyStimulus(8'h2C, 1'b1);
        checkOutput("poppush_noovf", 16'(o_overflow), 16'd0);
        checkHeld("poppush", 1'b1, 8'h2C, 1'b0, 16'd6);
        waitDrain("poppush");
        checkOutput("final_noovf", 16'(o_overflow), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Sits directly downstream of the PS/2 keyboard receiver and consumes its raw scan-code set 2 byte stream.
- Strips F0 (break) and E0 (extended) prefixes, discards the E1 Pause sequence and controller status bytes, and tracks the currently held key.
- Counts distinct key presses and queues decoded make/break events for the ASCII-map and seven-segment display logic.

Parameters:
- EVT_DEPTH, 4, event FIFO depth; must be a power of two, minimum 2.
- CNT_W, 16, press counter width.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- rst, input, 1, synchronous active-high reset.
- byte_valid, input, 1, single-cycle strobe: byte_data holds a received scan byte.
- byte_data, input, 8, received scan byte.
- key_held, output, 1, a key is currently held; acts as the display-enable source.
- key_code, output, 8, code of the held key, or of the last held key once released.
- key_ext, output, 1, held/last key was E0-prefixed.
- press_cnt, output, CNT_W, count of new key presses.
- evt_valid, output, 1, event FIFO is non-empty.
- evt_ready, input, 1, consumer accepts the head event.
- evt_code, output, 8, head event code.
- evt_ext, output, 1, head event is extended.
- evt_break, output, 1, head event is a release.
- evt_repeat, output, 1, head event is a typematic repeat (see optional feature).
- overflow, output, 1, sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; press_cnt 0; overflow 0.
- Input handshake: the block never backpressures. Every byte_valid cycle is consumed in that cycle.
- FSM states: IDLE, BRK, EXT, EXT_BRK, SKIP. Transitions on byte_valid only:
  - IDLE: F0 -> BRK; E0 -> EXT; E1 -> SKIP with skip counter = 7; any of 00, AA, EE, FA, FE, FF -> discarded, stay in IDLE; any other byte -> make(code, ext=0).
  - EXT: F0 -> EXT_BRK; E0, E1 or a status byte -> discard and return to IDLE; other byte -> make(code, ext=1), return to IDLE.
  - BRK: F0, E0, E1 or a status byte -> discard and return to IDLE; other byte -> break(code, ext=0), return to IDLE.
  - EXT_BRK: same as BRK, but issues break(code, ext=1).
  - SKIP: decrement the counter on each byte; the byte that takes it from 1 to 0 returns the FSM to IDLE. No events are produced.
- make(c, e):
  - Repeat case: key_held=1 and {key_ext, key_code}=={e, c}. This is typematic; press_cnt is unchanged and the event is handled per the optional feature.
  - Otherwise: key_code<=c, key_ext<=e, key_held<=1, press_cnt+1 (wraps modulo 2^CNT_W), and a make event is pushed.
- break(c, e):
  - If it matches the held key, key_held<=0 and key_code/key_ext are retained.
  - A non-matching break leaves the held state unchanged.
  - A break event is always pushed.
- Latency: the held-state registers, press_cnt and the FIFO write all update on the clock edge that samples the final byte of the sequence. evt_valid rises the next cycle if the FIFO was empty.
- Event FIFO:
  - Pop when evt_valid && evt_ready. evt_* show the head entry combinationally from the FIFO storage.
  - A push while full drops the new event and sets overflow; the FIFO contents are untouched.
  - Push and pop in the same cycle while full: the pop is taken first, so the push succeeds and overflow does not set.
  - Push and pop in the same cycle while empty: the push is stored and evt_valid=1 the next cycle.
  - overflow clears only on rst.
- Reset mid-sequence (for example after F0): the FSM returns to IDLE and the pending prefix is lost; the next byte is treated as fresh.
- byte_valid is ignored in the cycle where rst=1.

Optional Feature:
- Macro: PS2_KEY_REPEAT_EN.
- Defined: a typematic repeat pushes an event with evt_repeat=1, evt_break=0. press_cnt and the held state are unchanged.
- Undefined: repeats are silently discarded and evt_repeat is tied to 0.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 -> events {1C, make}, {1C, break}; key_held goes 1 then 0; press_cnt=1; key_code stays 1C.
- Bytes E0, 75, E0, F0, 75 -> events {75, ext=1, make}, {75, ext=1, break}; key_ext=1. Then byte 75 -> a new make with ext=0 (distinct key), press_cnt=2.
- Bytes 1C, 1C, 1C, F0, 1C -> press_cnt=1; 2 events without the macro; 4 events with it, the middle two having evt_repeat=1.
- Bytes E1, 14, 77, E1, F0, 14, F0, 77, then 16 -> only {16, make} is produced; the FSM is in IDLE after the 8th byte. Bytes AA and FA in IDLE -> no event.
- evt_ready=0 and EVT_DEPTH+1 make events (distinct keys) -> FIFO full, overflow=1, the first 4 events drain intact. Separately, a full FIFO with a simultaneous pop and push -> no overflow.
- Byte F0 then rst for one cycle, then byte 1C -> treated as a make, key_held=1, press_cnt=1; all outputs were 0 during reset.
